// File: rtl/c1908_reg.sv
// Registered 16-bit SEC/DED Hamming decoder using the c1908 port map, with optional bit injection and odd-parity mode.
// Latency: 1 clock. Inputs sampled at a rising edge appear on the outputs right after that edge.
// No flow control. hold=1 freezes the output registers, and rst overrides hold.
module c1908_reg (
   input  logic clk,
   input  logic rst,
   input  logic N1,  input logic N4,  input logic N7,  input logic N10,
   input  logic N13, input logic N16, input logic N19, input logic N22,
   input  logic N25, input logic N28, input logic N31, input logic N34,
   input  logic N37, input logic N40, input logic N43, input logic N46,
   input  logic N49, input logic N53, input logic N56, input logic N60,
   input  logic N63,
   input  logic N66,
   input  logic N69,
   input  logic N72,
   input  logic N76, input logic N79, input logic N82, input logic N85,
   input  logic N88,
   input  logic N91,
   input  logic N94,
   input  logic N99,
   input  logic N104,
   output logic N2753, output logic N2754, output logic N2755, output logic N2756,
   output logic N2762, output logic N2767, output logic N2768,
   output logic N2779, output logic N2780, output logic N2781, output logic N2782,
   output logic N2783, output logic N2784, output logic N2785, output logic N2786,
   output logic N2787,
   output logic N2811,
   output logic N2886, output logic N2887, output logic N2888, output logic N2889,
   output logic N2890,
   output logic N2891,
   output logic N2892,
   output logic N2899
);

   // Friendly names for the control inputs.
   logic       corr_en, flag_en, inject_en, data_inv, hold, parity_odd;
   logic [4:0] inject_pos;

   assign corr_en    = N69;
   assign flag_en    = N72;
   assign inject_en  = N91;
   assign data_inv   = N94;
   assign hold       = N99;
   assign parity_odd = N104;
   assign inject_pos = {N88, N85, N82, N79, N76};

   // Codeword indexed by Hamming position 1..21, so the syndrome points straight at the bad bit.
   logic [21:1] cw;
   logic [21:1] cw_fix;
   logic        par;
   logic [4:0]  syn;
   logic        pm;
   logic        no_err, single, dbl;
   logic [15:0] data_fix;
   logic [15:0] q_next;

   // Place the received bits and apply polarity correction and injection.
   always_comb begin
      cw      = '0;
      cw[1]   = N49 ^ parity_odd;
      cw[2]   = N53 ^ parity_odd;
      cw[4]   = N56 ^ parity_odd;
      cw[8]   = N60 ^ parity_odd;
      cw[16]  = N63 ^ parity_odd;
      cw[3]   = N1;
      cw[5]   = N4;
      cw[6]   = N7;
      cw[7]   = N10;
      cw[9]   = N13;
      cw[10]  = N16;
      cw[11]  = N19;
      cw[12]  = N22;
      cw[13]  = N25;
      cw[14]  = N28;
      cw[15]  = N31;
      cw[17]  = N34;
      cw[18]  = N37;
      cw[19]  = N40;
      cw[20]  = N43;
      cw[21]  = N46;
      // Position 0 and positions 22..31 do not match any loop index, so those values inject nothing.
      for (int p = 1; p <= 21; p++) begin
         if (inject_en && (inject_pos == 5'(p)))
            cw[p] = ~cw[p];
      end
   end

   assign par = N66 ^ parity_odd;

   // Syndrome bit k is the parity of every codeword position that has bit k set.
   always_comb begin
      syn = '0;
      for (int p = 1; p <= 21; p++) begin
         for (int k = 0; k < 5; k++) begin
            if (p[k])
               syn[k] = syn[k] ^ cw[p];
         end
      end
   end

   assign pm = (^cw) ^ par;

   // Classify the error. pm=1 with s=0 means P itself flipped, which still counts as a single error.
   always_comb begin
      no_err = (syn == 5'd0) && !pm;
      single = pm && (syn <= 5'd21);
      dbl    = (pm && (syn > 5'd21)) || (!pm && (syn != 5'd0));
   end

   // Flip the position named by the syndrome. Check-bit positions are flipped too, but they are never extracted.
   always_comb begin
      cw_fix = cw;
      for (int p = 1; p <= 21; p++) begin
         if (single && corr_en && (syn == 5'(p)))
            cw_fix[p] = ~cw_fix[p];
      end
      data_fix = {cw_fix[21], cw_fix[20], cw_fix[19], cw_fix[18], cw_fix[17],
                  cw_fix[15], cw_fix[14], cw_fix[13], cw_fix[12], cw_fix[11],
                  cw_fix[10], cw_fix[9],  cw_fix[7],  cw_fix[6],  cw_fix[5],
                  cw_fix[3]};
      q_next   = data_fix ^ {16{data_inv}};
   end

   logic [15:0] q_reg;
   logic [4:0]  syn_reg;
   logic        err_any_reg, pm_reg, single_reg, dbl_reg;

   // Output registers. Reset wins over hold, and flag_en gates only the status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg       <= '0;
         syn_reg     <= '0;
         err_any_reg <= 1'b0;
         pm_reg      <= 1'b0;
         single_reg  <= 1'b0;
         dbl_reg     <= 1'b0;
      end else if (!hold) begin
         q_reg       <= q_next;
         syn_reg     <= flag_en ? syn : 5'd0;
         err_any_reg <= flag_en && !no_err;
         pm_reg      <= flag_en && pm;
         single_reg  <= flag_en && single;
         dbl_reg     <= flag_en && dbl;
      end
   end

   assign {N2787, N2786, N2785, N2784, N2783, N2782, N2781, N2780, N2779,
           N2768, N2767, N2762, N2756, N2755, N2754, N2753} = q_reg;
   assign N2811 = err_any_reg;
   assign {N2890, N2889, N2888, N2887, N2886} = syn_reg;
   assign N2891 = pm_reg;
   assign N2892 = single_reg;
   assign N2899 = dbl_reg;

endmodule

// File: tb/tb_c1908_reg.sv
// Directed bench for c1908_reg. Each vector carries hand-computed expected data and status.
// Inputs change 1 ns after a rising edge, and outputs are checked 1 ns after the next rising edge.
// Status is packed as {err_any, s[4:0], pm, single, double}.
module tb_c1908_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] d;
   logic [4:0]  c;
   logic        p, corr_en, flag_en, inj_en, data_inv, hold, par_odd;
   logic [4:0]  inj_pos;

   wire  [15:0] q;
   wire  [4:0]  s;
   wire         err_any, pm, single, dbl;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   c1908_reg dut (
      .clk(clk), .rst(rst),
      .N1(d[0]),   .N4(d[1]),   .N7(d[2]),   .N10(d[3]),
      .N13(d[4]),  .N16(d[5]),  .N19(d[6]),  .N22(d[7]),
      .N25(d[8]),  .N28(d[9]),  .N31(d[10]), .N34(d[11]),
      .N37(d[12]), .N40(d[13]), .N43(d[14]), .N46(d[15]),
      .N49(c[0]), .N53(c[1]), .N56(c[2]), .N60(c[3]), .N63(c[4]),
      .N66(p), .N69(corr_en), .N72(flag_en),
      .N76(inj_pos[0]), .N79(inj_pos[1]), .N82(inj_pos[2]), .N85(inj_pos[3]), .N88(inj_pos[4]),
      .N91(inj_en), .N94(data_inv), .N99(hold), .N104(par_odd),
      .N2753(q[0]), .N2754(q[1]), .N2755(q[2]), .N2756(q[3]),
      .N2762(q[4]), .N2767(q[5]), .N2768(q[6]),
      .N2779(q[7]),  .N2780(q[8]),  .N2781(q[9]),  .N2782(q[10]),
      .N2783(q[11]), .N2784(q[12]), .N2785(q[13]), .N2786(q[14]),
      .N2787(q[15]),
      .N2811(err_any),
      .N2886(s[0]), .N2887(s[1]), .N2888(s[2]), .N2889(s[3]), .N2890(s[4]),
      .N2891(pm), .N2892(single), .N2899(dbl)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Clock one vector through the DUT, then compare data and status.
   task automatic step(input string tag, input logic [15:0] exp_q, input logic [8:0] exp_st);
      @(posedge clk);
      #1;
      check({tag, " q"},      32'(q), 32'(exp_q));
      check({tag, " status"}, 32'({err_any, s, pm, single, dbl}), 32'(exp_st));
   endtask

   task automatic set_base();
      rst = 1'b0; d = '0; c = '0; p = 1'b0;
      corr_en = 1'b1; flag_en = 1'b1; inj_en = 1'b0; inj_pos = '0;
      data_inv = 1'b0; hold = 1'b0; par_odd = 1'b0;
   endtask

   initial begin
      set_base();
      // Reset with arbitrary, error-laden inputs applied.
      rst = 1'b1; d = 16'hA5A5; c = 5'h13; p = 1'b1; data_inv = 1'b1;
      step("rst0", 16'h0000, 9'b0_00000_0_0_0);
      step("rst1", 16'h0000, 9'b0_00000_0_0_0);

      set_base();
      step("clean", 16'h0000, 9'b0_00000_0_0_0);

      d = 16'h0001;                                   // D0 at position 3 flipped
      step("d0_corr", 16'h0000, 9'b1_00011_1_1_0);
      corr_en = 1'b0;
      step("d0_nocorr", 16'h0001, 9'b1_00011_1_1_0);

      set_base(); d = 16'h0003;                       // positions 3 and 5: s=6, pm=0
      step("double", 16'h0003, 9'b1_00110_0_0_1);

      set_base(); inj_en = 1'b1; inj_pos = 5'd5;
      step("inj5", 16'h0000, 9'b1_00101_1_1_0);
      inj_pos = 5'd0;
      step("inj0", 16'h0000, 9'b0_00000_0_0_0);
      inj_pos = 5'd21; corr_en = 1'b0;                // D15, uncorrected
      step("inj21", 16'h8000, 9'b1_10101_1_1_0);
      inj_pos = 5'd22;
      step("inj22", 16'h0000, 9'b0_00000_0_0_0);

      // Positions 3, 8 and 16 give s=27 and pm=1, which is uncorrectable.
      set_base(); d = 16'h0001; c = 5'b11000;
      step("uncorr", 16'h0001, 9'b1_11011_1_0_1);

      set_base(); p = 1'b1;                            // only P flipped
      step("p_err", 16'h0000, 9'b1_00000_1_1_0);
      set_base(); c = 5'b00100;                       // C2 at position 4
      step("c2_err", 16'h0000, 9'b1_00100_1_1_0);

      set_base(); par_odd = 1'b1; c = 5'b11111; p = 1'b1;
      step("odd_clean", 16'h0000, 9'b0_00000_0_0_0);
      data_inv = 1'b1;
      step("odd_inv", 16'hFFFF, 9'b0_00000_0_0_0);

      set_base(); flag_en = 1'b0; d = 16'h0001;
      step("flag_off", 16'h0000, 9'b0_00000_0_0_0);

      set_base(); d = 16'h0003;
      step("pre_hold", 16'h0003, 9'b1_00110_0_0_1);
      hold = 1'b1; d = 16'h1234; c = 5'h1F;
      step("hold0", 16'h0003, 9'b1_00110_0_0_1);
      d = 16'h0000; c = 5'h00;
      step("hold1", 16'h0003, 9'b1_00110_0_0_1);
      rst = 1'b1;
      step("rst_hold", 16'h0000, 9'b0_00000_0_0_0);
      set_base(); d = 16'h0003;
      step("resume", 16'h0003, 9'b1_00110_0_0_1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
